// File: rtl/z80_pfx_pkg.sv
// Shared definitions for the Z80 opcode-prefix sequencer: FSM states, page and
// index encodings, prefix byte values and the H/L/(HL) usage classifier.
package z80_pfx_pkg;

    typedef enum logic [2:0] {
        ST_MAIN   = 3'd0,
        ST_IDX    = 3'd1,
        ST_CB     = 3'd2,
        ST_ED     = 3'd3,
        ST_XCB_D  = 3'd4,
        ST_XCB_OP = 3'd5
    } pfx_state_t;

    localparam logic [1:0] PAGE_MAIN = 2'b00;
    localparam logic [1:0] PAGE_CB   = 2'b01;
    localparam logic [1:0] PAGE_ED   = 2'b10;
    localparam logic [1:0] PAGE_XCB  = 2'b11;

    localparam logic [1:0] IDX_HL = 2'b00;
    localparam logic [1:0] IDX_IX = 2'b01;
    localparam logic [1:0] IDX_IY = 2'b10;

    localparam logic [7:0] PFX_CB = 8'hCB;
    localparam logic [7:0] PFX_DD = 8'hDD;
    localparam logic [7:0] PFX_ED = 8'hED;
    localparam logic [7:0] PFX_FD = 8'hFD;

    // True for main-page opcodes whose operands include H, L or (HL), i.e. the
    // ones an index prefix actually redirects to IX/IY.
    function automatic logic uses_hl(input logic [7:0] b);
        logic [1:0] x;
        logic [2:0] y;
        logic [2:0] z;
        logic       hl_y;
        logic       hl_z;
        x    = b[7:6];
        y    = b[5:3];
        z    = b[2:0];
        hl_y = (y == 3'd4) || (y == 3'd5) || (y == 3'd6);
        hl_z = (z == 3'd4) || (z == 3'd5) || (z == 3'd6);
        uses_hl = 1'b0;
        case (x)
            2'd0: begin
                case (z)
                    // LD HL,nn / ADD HL,rp / LD (nn),HL / LD HL,(nn) / INC,DEC HL
                    3'd1:    uses_hl = (b[5:4] == 2'd2) || b[3];
                    3'd2:    uses_hl = (b[5:4] == 2'd2);
                    3'd3:    uses_hl = (b[5:4] == 2'd2);
                    // INC r / DEC r / LD r,n with r in H, L, (HL)
                    3'd4:    uses_hl = hl_y;
                    3'd5:    uses_hl = hl_y;
                    3'd6:    uses_hl = hl_y;
                    default: uses_hl = 1'b0;
                endcase
            end
            // LD r,r' except HALT
            2'd1:    uses_hl = (b != 8'h76) && (hl_y || hl_z);
            // ALU A,r
            2'd2:    uses_hl = hl_z;
            // POP HL, EX (SP),HL, PUSH HL, JP (HL), LD SP,HL
            default: uses_hl = (b == 8'hE1) || (b == 8'hE3) || (b == 8'hE5) ||
                               (b == 8'hE9) || (b == 8'hF9);
        endcase
    endfunction

endpackage

// File: rtl/z80_r_reg.sv
// Z80 refresh register: loadable, low R_BITS bits count up and wrap while the
// bits above them are preserved.
module z80_r_reg #(
    parameter int R_BITS = 7
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       inc,
    input  logic       ld,
    input  logic [7:0] din,
    output logic [7:0] r_out
);

    // Computed in 9 bits so R_BITS=8 yields an all-ones mask.
    localparam logic [8:0] MASK9    = (9'd1 << R_BITS) - 9'd1;
    localparam logic [7:0] LOW_MASK = MASK9[7:0];

    logic [7:0] r_r;
    logic [7:0] w_r_inc;

    assign w_r_inc = (r_r & ~LOW_MASK) | ((r_r + 8'd1) & LOW_MASK);
    assign r_out   = r_r;

    // Load has priority over the M1 increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_r <= 8'h00;
        end else if (ld) begin
            r_r <= din;
        end else if (inc) begin
            r_r <= w_r_inc;
        end
    end

endmodule

// File: rtl/z80_prefix_seq.sv
// Z80 opcode-prefix sequencer. Follows CB/ED/DD/FD chains between the M1
// fetch path and the decoder, emits the final opcode with its page and index
// selection, and keeps the R register.
// Optional build macro Z80_PFX_STATS_EN adds a saturating count of discarded
// index prefixes (pfx_drop_cnt) with a synchronous clear (pfx_drop_clr).
//
// Handshake: fetch_valid qualifies fetch_byte for exactly one cycle; there is
// no backpressure. op_valid / disp_valid are single-cycle pulses one clock
// after the accepting fetch; every other output is a held register.
module z80_prefix_seq
    import z80_pfx_pkg::*;
#(
    parameter int R_BITS    = 7,
    parameter int CHAIN_W   = 4,
    parameter int MODE_8080 = 0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               fetch_valid,
    input  logic [7:0]         fetch_byte,
    input  logic               r_ld,
    input  logic [7:0]         r_din,
`ifdef Z80_PFX_STATS_EN
    input  logic               pfx_drop_clr,
    output logic [15:0]        pfx_drop_cnt,
`endif
    output logic               op_valid,
    output logic [7:0]         op_byte,
    output logic [1:0]         page,
    output logic [1:0]         idx_sel,
    output logic               idx_ignored,
    output logic               disp_valid,
    output logic [7:0]         disp,
    output logic [CHAIN_W-1:0] chain_cnt,
    output logic [7:0]         r_out,
    output logic               int_block,
    output logic [2:0]         dbg_state
);

    localparam logic [CHAIN_W-1:0] CNT_MAX = '1;
    localparam logic [CHAIN_W-1:0] CNT_ONE = CHAIN_W'(1);

    pfx_state_t         r_state;
    logic               r_op_valid;
    logic [7:0]         r_op_byte;
    logic [1:0]         r_page;
    logic [1:0]         r_idx;
    logic               r_idx_ignored;
    logic               r_disp_valid;
    logic [7:0]         r_disp;
    logic [CHAIN_W-1:0] r_chain_cnt;
    logic               r_int_block;

    logic               w_is_idx_pfx;
    logic [1:0]         w_pfx_idx;
    logic [CHAIN_W-1:0] w_cnt_inc;
    logic               w_m1_state;
    logic               w_r_inc;

    assign w_is_idx_pfx = (fetch_byte == PFX_DD) || (fetch_byte == PFX_FD);
    assign w_pfx_idx    = (fetch_byte == PFX_DD) ? IDX_IX : IDX_IY;
    assign w_cnt_inc    = (r_chain_cnt == CNT_MAX) ? CNT_MAX : r_chain_cnt + CNT_ONE;

    // Only opcode fetches (M1) bump R; the DDCB/FDCB displacement and opcode
    // are ordinary memory reads.
    assign w_m1_state = (r_state == ST_MAIN) || (r_state == ST_IDX) ||
                        (r_state == ST_CB)   || (r_state == ST_ED);
    assign w_r_inc    = fetch_valid && (MODE_8080 == 0) && w_m1_state;

    z80_r_reg #(
        .R_BITS (R_BITS)
    ) u_r_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (w_r_inc),
        .ld      (r_ld),
        .din     (r_din),
        .r_out   (r_out)
    );

    // Prefix-chain FSM with all decoder-facing outputs registered alongside it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_MAIN;
            r_op_valid    <= 1'b0;
            r_op_byte     <= 8'h00;
            r_page        <= PAGE_MAIN;
            r_idx         <= IDX_HL;
            r_idx_ignored <= 1'b0;
            r_disp_valid  <= 1'b0;
            r_disp        <= 8'h00;
            r_chain_cnt   <= '0;
            r_int_block   <= 1'b0;
        end else begin
            r_op_valid   <= 1'b0;
            r_disp_valid <= 1'b0;
            if (fetch_valid) begin
                if (MODE_8080 != 0) begin
                    // 8080 mode: every byte is a complete main-page opcode.
                    r_op_valid    <= 1'b1;
                    r_op_byte     <= fetch_byte;
                    r_page        <= PAGE_MAIN;
                    r_idx         <= IDX_HL;
                    r_idx_ignored <= 1'b0;
                    r_chain_cnt   <= '0;
                    r_state       <= ST_MAIN;
                    r_int_block   <= 1'b0;
                end else begin
                    case (r_state)
                        ST_MAIN: begin
                            // First byte of a new instruction: previous
                            // instruction's chain info is dropped here.
                            r_idx_ignored <= 1'b0;
                            r_idx         <= IDX_HL;
                            r_chain_cnt   <= '0;
                            if (fetch_byte == PFX_CB) begin
                                r_chain_cnt <= CNT_ONE;
                                r_state     <= ST_CB;
                                r_int_block <= 1'b1;
                            end else if (fetch_byte == PFX_ED) begin
                                r_chain_cnt <= CNT_ONE;
                                r_state     <= ST_ED;
                                r_int_block <= 1'b1;
                            end else if (w_is_idx_pfx) begin
                                r_idx       <= w_pfx_idx;
                                r_chain_cnt <= CNT_ONE;
                                r_state     <= ST_IDX;
                                r_int_block <= 1'b1;
                            end else begin
                                r_op_valid  <= 1'b1;
                                r_op_byte   <= fetch_byte;
                                r_page      <= PAGE_MAIN;
                                r_state     <= ST_MAIN;
                                r_int_block <= 1'b0;
                            end
                        end
                        ST_IDX: begin
                            if (w_is_idx_pfx) begin
                                // Last index prefix in a run wins.
                                r_idx       <= w_pfx_idx;
                                r_chain_cnt <= w_cnt_inc;
                                r_state     <= ST_IDX;
                                r_int_block <= 1'b1;
                            end else if (fetch_byte == PFX_ED) begin
                                // ED cancels any pending index prefix.
                                r_idx       <= IDX_HL;
                                r_chain_cnt <= w_cnt_inc;
                                r_state     <= ST_ED;
                                r_int_block <= 1'b1;
                            end else if (fetch_byte == PFX_CB) begin
                                r_chain_cnt <= w_cnt_inc;
                                r_state     <= ST_XCB_D;
                                r_int_block <= 1'b1;
                            end else begin
                                r_op_valid    <= 1'b1;
                                r_op_byte     <= fetch_byte;
                                r_page        <= PAGE_MAIN;
                                r_idx_ignored <= !uses_hl(fetch_byte);
                                r_state       <= ST_MAIN;
                                r_int_block   <= 1'b0;
                            end
                        end
                        ST_CB: begin
                            r_op_valid  <= 1'b1;
                            r_op_byte   <= fetch_byte;
                            r_page      <= PAGE_CB;
                            r_idx       <= IDX_HL;
                            r_state     <= ST_MAIN;
                            r_int_block <= 1'b0;
                        end
                        ST_ED: begin
                            r_op_valid  <= 1'b1;
                            r_op_byte   <= fetch_byte;
                            r_page      <= PAGE_ED;
                            r_idx       <= IDX_HL;
                            r_state     <= ST_MAIN;
                            r_int_block <= 1'b0;
                        end
                        ST_XCB_D: begin
                            r_disp       <= fetch_byte;
                            r_disp_valid <= 1'b1;
                            r_state      <= ST_XCB_OP;
                            r_int_block  <= 1'b1;
                        end
                        ST_XCB_OP: begin
                            r_op_valid  <= 1'b1;
                            r_op_byte   <= fetch_byte;
                            r_page      <= PAGE_XCB;
                            r_state     <= ST_MAIN;
                            r_int_block <= 1'b0;
                        end
                        default: begin
                            r_state     <= ST_MAIN;
                            r_int_block <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

`ifdef Z80_PFX_STATS_EN
    logic [15:0] r_drop_cnt;
    logic        w_drop_evt;

    // One discard per overridden index prefix, per index prefix cancelled by
    // ED, and per indexed instruction that never touches H/L/(HL).
    assign w_drop_evt = fetch_valid && (MODE_8080 == 0) && (r_state == ST_IDX) &&
                        (w_is_idx_pfx || (fetch_byte == PFX_ED) ||
                         ((fetch_byte != PFX_CB) && !uses_hl(fetch_byte)));

    // Saturating discard counter; clear has priority.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_drop_cnt <= 16'h0000;
        end else if (pfx_drop_clr) begin
            r_drop_cnt <= 16'h0000;
        end else if (w_drop_evt && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign pfx_drop_cnt = r_drop_cnt;
`endif

    assign op_valid    = r_op_valid;
    assign op_byte     = r_op_byte;
    assign page        = r_page;
    assign idx_sel     = r_idx;
    assign idx_ignored = r_idx_ignored;
    assign disp_valid  = r_disp_valid;
    assign disp        = r_disp;
    assign chain_cnt   = r_chain_cnt;
    assign int_block   = r_int_block;
    assign dbg_state   = r_state;

endmodule
